// File: rtl/seg_marquee_scroller.sv
// -----------------------------------------------------------------------------
// seg_marquee_scroller
//
// Scrolling-text engine for a multi-digit 7-segment display. A message of
// symbol codes lives in an internal buffer; a window of N_DIGITS symbols
// slides across it right to left, one position per scroll tick. The
// per-digit symbol codes are output for downstream decode/multiplexing.
//
// Optional feature macro: MARQUEE_PAUSE_EN
//   defined   : pause=1 in SCROLL freezes the tick counter, pos and digits.
//   undefined : the pause port is present but has no effect.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous, active-high reset
//   wr_en    in   write one symbol into the buffer
//   wr_addr  in   buffer write index (writes at or beyond MAX_LEN are dropped)
//   wr_data  in   symbol to write
//   msg_len  in   message length, sampled on start (clamped to MAX_LEN)
//   loop     in   1 = repeat forever, 0 = one-shot; sampled on start
//   start    in   pulse: begin scrolling from position 0 (restarts if busy)
//   stop     in   pulse: abort to idle (wins over start)
//   pause    in   freeze scrolling (MARQUEE_PAUSE_EN builds only)
//   digits   out  digit k at [k*SYM_W +: SYM_W], k=0 is the leftmost digit
//   busy     out  high while scrolling
//   done     out  one-cycle pulse at one-shot completion
//   pos      out  current window position
// -----------------------------------------------------------------------------
module seg_marquee_scroller #(
    parameter int               N_DIGITS = 8,
    parameter int               MAX_LEN  = 32,
    parameter int               SYM_W    = 5,
    parameter logic [SYM_W-1:0] BLANK    = 5'd31,
    parameter int               TICK_DIV = 7_000_000
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         wr_en,
    input  logic [$clog2(MAX_LEN)-1:0]                   wr_addr,
    input  logic [SYM_W-1:0]                             wr_data,
    input  logic [$clog2(MAX_LEN):0]                     msg_len,
    input  logic                                         loop,
    input  logic                                         start,
    input  logic                                         stop,
    input  logic                                         pause,
    output logic [N_DIGITS*SYM_W-1:0]                    digits,
    output logic                                         busy,
    output logic                                         done,
    output logic [$clog2(MAX_LEN+N_DIGITS):0]            pos
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int LW = AW + 1;
    localparam int PW = $clog2(MAX_LEN + N_DIGITS) + 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // One extra bit so pos + k never wraps before N_DIGITS is subtracted.
    localparam int IW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCROLL,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [LW-1:0]    len_q, len_d;
    logic             loop_q, loop_d;
    logic [PW-1:0]    p_end;
    logic             hold;
    logic             wr_ok;

    logic [SYM_W-1:0]              msg_mem [MAX_LEN];
    logic [N_DIGITS*SYM_W-1:0]     win_p0;
    logic [N_DIGITS*SYM_W-1:0]     digits_p1;

    // Effective message length: requested length saturated to buffer depth.
    function automatic logic [LW-1:0] sat_len(input logic [LW-1:0] req);
        if (req > LW'(MAX_LEN)) begin
            return LW'(MAX_LEN);
        end
        return req;
    endfunction

`ifdef MARQUEE_PAUSE_EN
    assign hold = pause && (state_q == ST_SCROLL);
`else
    // Pause is inert in this build; the AND keeps the port tied into logic
    // that folds away to constant zero.
    assign hold = pause & 1'b0;
`endif

    // Zero-extended compare so the check stays meaningful for any MAX_LEN.
    assign wr_ok = (LW'(wr_addr) < LW'(MAX_LEN));

    // Last window position: the message has fully slid off the left edge.
    assign p_end = PW'(len_q) + PW'(N_DIGITS);

    // -------------------------------------------------------------------------
    // Message buffer: writable in any state, never cleared by reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            msg_mem[wr_addr] <= wr_data;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pos_q   <= '0;
            tick_q  <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            tick_q  <= tick_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        tick_d  = tick_q;
        len_d   = len_q;
        loop_d  = loop_q;

        if (stop) begin
            state_d = ST_IDLE;
            pos_d   = '0;
            tick_d  = '0;
        end else if (start) begin
            // Start is honoured in every state; an empty message goes
            // straight to DONE so the requester still sees completion.
            len_d   = sat_len(msg_len);
            loop_d  = loop;
            pos_d   = '0;
            tick_d  = '0;
            state_d = (sat_len(msg_len) == '0) ? ST_DONE : ST_SCROLL;
        end else begin
            case (state_q)
                ST_SCROLL: begin
                    if (!hold) begin
                        if (tick_q == TW'(TICK_DIV - 1)) begin
                            tick_d = '0;
                            if (pos_q == p_end) begin
                                if (loop_q) begin
                                    pos_d = '0;
                                end else begin
                                    // pos stays at p_end so the window is blank
                                    state_d = ST_DONE;
                                end
                            end else begin
                                pos_d = pos_q + 1'b1;
                            end
                        end else begin
                            tick_d = tick_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Stage p0: window lookup, idx = pos - N_DIGITS + k
    // -------------------------------------------------------------------------
    always_comb begin
        logic [IW-1:0]    idx_raw;
        logic [IW-1:0]    idx;
        logic [SYM_W-1:0] sym;
        win_p0 = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            idx_raw = IW'(pos_q) + IW'(k);
            idx     = '0;
            sym     = BLANK;
            // idx_raw < N_DIGITS means the symbol index would be negative.
            if (idx_raw >= IW'(N_DIGITS)) begin
                idx = idx_raw - IW'(N_DIGITS);
                if (idx < IW'(len_q)) begin
                    sym = msg_mem[idx[AW-1:0]];
                end
            end
            win_p0[k*SYM_W +: SYM_W] = sym;
        end
    end

    // -------------------------------------------------------------------------
    // Stage p1: registered digit outputs
    // -------------------------------------------------------------------------
    // Stop blanks on the same edge that returns the FSM to idle. While held,
    // the register keeps its contents so a buffer write cannot disturb a
    // frozen display; a start always refreshes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            digits_p1 <= {N_DIGITS{BLANK}};
        end else if (stop || (state_q == ST_IDLE)) begin
            digits_p1 <= {N_DIGITS{BLANK}};
        end else if (!hold || start) begin
            digits_p1 <= win_p0;
        end
    end

    assign digits = digits_p1;
    assign busy   = (state_q == ST_SCROLL);
    assign done   = (state_q == ST_DONE);
    assign pos    = pos_q;

endmodule

// File: tb/tb_seg_marquee_scroller.sv
module tb_seg_marquee_scroller;

    localparam int N  = 8;
    localparam int ML = 32;
    localparam int SW = 5;
    localparam int TD = 4;
    localparam int AW = 5;
    localparam int LW = 6;
    localparam int PW = 7;
    localparam logic [SW-1:0] BLK = 5'd31;

    logic clk = 1'b0;
    logic rst, wr_en, loop, start, stop, pause;
    logic [AW-1:0]   wr_addr;
    logic [SW-1:0]   wr_data;
    logic [LW-1:0]   msg_len;
    logic [N*SW-1:0] digits;
    logic            busy, done;
    logic [PW-1:0]   pos;

    always #5 clk = ~clk;

    seg_marquee_scroller #(
        .N_DIGITS (N),
        .MAX_LEN  (ML),
        .SYM_W    (SW),
        .BLANK    (BLK),
        .TICK_DIV (TD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .msg_len (msg_len),
        .loop    (loop),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .digits  (digits),
        .busy    (busy),
        .done    (done),
        .pos     (pos)
    );

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [SW-1:0] ref_mem [ML];

    typedef struct {
        logic [PW-1:0]   pos;
        logic [N*SW-1:0] digits;
    } snap_t;
    snap_t exp_q[$];
    bit    mon_en = 1'b0;

    typedef struct {
        int msg_len;
        int exp_len;
        int exp_cycles;
    } run_t;

    localparam logic [N*SW-1:0] ALL_BLANK = {N{BLK}};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected window contents at position p for a message of length len.
    function automatic logic [N*SW-1:0] exp_win(input int p, input int len);
        logic [N*SW-1:0] r;
        int idx;
        r = '0;
        for (int k = 0; k < N; k++) begin
            idx = p - N + k;
            if (idx >= 0 && idx < len) r[k*SW +: SW] = ref_mem[idx];
            else                       r[k*SW +: SW] = BLK;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [SW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        ref_mem[a] = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(input int len, input logic lp);
        msg_len = LW'(len);
        loop    = lp;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Monitor: counts done pulses and, while enabled, pops one expected
    // snapshot per window position once the digits have caught up with pos.
    int            age = 0;
    logic          was_busy = 1'b0;
    logic [PW-1:0] last_pos = '0;
    always @(posedge clk) begin
        #2;
        if (done === 1'b1) done_cnt++;
        if (mon_en && busy === 1'b1) begin
            if (!was_busy || pos != last_pos) age = 0;
            else age++;
            if (age == 1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow: got pos %0d with no expected entry", pos);
                end else begin
                    snap_t e;
                    e = exp_q.pop_front();
                    check("sb_pos", 64'(pos), 64'(e.pos));
                    check("sb_digits", 64'(digits), 64'(e.digits));
                end
            end
        end
        was_busy = busy;
        last_pos = pos;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        run_t            runs[5];
        int              n;
        int              d0;
        logic [N*SW-1:0] saved;

        runs[0] = '{3,  3,  48};
        runs[1] = '{0,  0,  0};
        runs[2] = '{40, 32, 164};
        runs[3] = '{5,  5,  56};
        runs[4] = '{32, 32, 164};

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        msg_len = '0; loop = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        repeat (3) tick();

        check("reset_busy",   64'(busy),   64'(0));
        check("reset_done",   64'(done),   64'(0));
        check("reset_pos",    64'(pos),    64'(0));
        check("reset_digits", 64'(digits), 64'(ALL_BLANK));

        // reset wins over start
        msg_len = 6'd3; start = 1'b1;
        tick();
        start = 1'b0;
        check("rst_over_start_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        tick();

        for (int i = 0; i < ML; i++) begin
            if (i < 3) wr(i, SW'(i + 1));
            else       wr(i, SW'((i * 5 + 4) % 31));
        end

        // One-shot runs: completion time and every window position.
        for (int r = 0; r < 5; r++) begin
            d0 = done_cnt;
            if (runs[r].exp_len > 0) begin
                for (int p = 0; p <= runs[r].exp_len + N; p++)
                    exp_q.push_back('{PW'(p), exp_win(p, runs[r].exp_len)});
            end
            mon_en = 1'b1;
            pulse_start(runs[r].msg_len, 1'b0);
            n = 0;
            while (done !== 1'b1 && n < runs[r].exp_cycles + 40) begin
                tick();
                n++;
            end
            check("run_done_cycle",   64'(n),      64'(runs[r].exp_cycles));
            check("run_busy_at_done", 64'(busy),   64'(0));
            check("run_blank_at_done",64'(digits), 64'(ALL_BLANK));
            tick();
            check("run_done_width",   64'(done),   64'(0));
            mon_en = 1'b0;
            check("run_sb_drained",   64'(exp_q.size()), 64'(0));
            exp_q.delete();
            check("run_done_count",   64'(done_cnt - d0), 64'(1));
            tick();
        end

        // Loop mode: wraps to 0 after pos 11, never pulses done.
        d0 = done_cnt;
        pulse_start(3, 1'b1);
        repeat (48) tick();
        check("loop_wrap_pos",  64'(pos),  64'(0));
        check("loop_wrap_busy", 64'(busy), 64'(1));
        repeat (4) tick();
        check("loop_pos1", 64'(pos), 64'(1));
        repeat (96) tick();
        check("loop_pass3_pos",  64'(pos), 64'(1));
        check("loop_no_done",    64'(done_cnt - d0), 64'(0));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("loop_stop_busy", 64'(busy), 64'(0));
        repeat (3) tick();
        check("loop_stop_no_done", 64'(done_cnt - d0), 64'(0));

        // Stop at pos 5.
        d0 = done_cnt;
        pulse_start(3, 1'b0);
        repeat (21) tick();
        check("mid_pos", 64'(pos), 64'(5));
        check("mid_digits", 64'(digits), 64'({BLK, BLK, 5'd3, 5'd2, 5'd1, BLK, BLK, BLK}));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_busy", 64'(busy), 64'(0));
        tick();
        check("stop_digits", 64'(digits), 64'(ALL_BLANK));
        repeat (3) tick();
        check("stop_no_done", 64'(done_cnt - d0), 64'(0));

        // Restart with start at pos 5.
        d0 = done_cnt;
        pulse_start(3, 1'b0);
        repeat (21) tick();
        pulse_start(3, 1'b0);
        check("restart_pos0", 64'(pos),  64'(0));
        check("restart_busy", 64'(busy), 64'(1));
        repeat (3) tick();
        check("restart_pos_hold", 64'(pos), 64'(0));
        tick();
        check("restart_pos1", 64'(pos), 64'(1));
        repeat (44) tick();
        check("restart_done", 64'(done), 64'(1));
        tick();
        check("restart_done_count", 64'(done_cnt - d0), 64'(1));

        // Write to a visible index: old value on the write edge, new one after.
        pulse_start(3, 1'b0);
        repeat (13) tick();
        check("vis_pos3", 64'(digits), 64'({5'd3, 5'd2, 5'd1, BLK, BLK, BLK, BLK, BLK}));
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 5'd20;
        tick();
        wr_en = 1'b0;
        check("wr_same_cycle_old", 64'(digits[6*SW +: SW]), 64'(2));
        tick();
        check("wr_visible_new", 64'(digits[6*SW +: SW]), 64'(20));
        wr(1, 5'd2);

        // stop and start together: stop wins.
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("stop_over_start", 64'(busy), 64'(0));
        tick();

        // Reset mid-scroll; buffer survives.
        pulse_start(3, 1'b0);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy",   64'(busy),   64'(0));
        check("rst_mid_pos",    64'(pos),    64'(0));
        check("rst_mid_digits", 64'(digits), 64'(ALL_BLANK));
        check("rst_mid_done",   64'(done),   64'(0));
        pulse_start(3, 1'b0);
        repeat (13) tick();
        check("rst_buf_kept", 64'(digits), 64'({5'd3, 5'd2, 5'd1, BLK, BLK, BLK, BLK, BLK}));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();

        // Pause at pos 4 for 20 cycles.
        pulse_start(3, 1'b0);
        repeat (17) tick();
        check("pause_pre_pos", 64'(pos), 64'(4));
        saved = digits;
        pause = 1'b1;
`ifdef MARQUEE_PAUSE_EN
        repeat (20) tick();
        check("pause_pos_held",    64'(pos),    64'(4));
        check("pause_digits_held", 64'(digits), 64'(saved));
        pause = 1'b0;
        repeat (2) tick();
        check("pause_resume_wait", 64'(pos), 64'(4));
        tick();
        check("pause_resume_step", 64'(pos), 64'(5));
`else
        repeat (3) tick();
        check("pause_ignored_pos5", 64'(pos), 64'(5));
        repeat (4) tick();
        check("pause_ignored_pos6", 64'(pos), 64'(6));
        pause = 1'b0;
`endif
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_marquee_scroller.md
Name: seg_marquee_scroller

Overview:
- Parametrised scrolling-text engine for the multi-digit 7-segment display.
- Holds a message of symbol codes in an internal buffer and slides a window of N_DIGITS symbols across it, right to left, one position per scroll tick.
- Outputs the per-digit symbol codes. Downstream symbol decode and digit multiplexing turn these into segment patterns.
- Adds runtime message length, one-shot/loop modes and a done handshake.

Parameters:
- N_DIGITS, 8, number of display digits in the window.
- MAX_LEN, 32, message buffer depth in symbols.
- SYM_W, 5, symbol code width.
- BLANK, 5'd31, symbol code for an unlit digit.
- TICK_DIV, 7_000_000, clk cycles per scroll step.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  write one symbol into the buffer.
- wr_addr  in  clog2(MAX_LEN)  buffer write index.
- wr_data  in  SYM_W  symbol written.
- msg_len  in  clog2(MAX_LEN)+1  message length, sampled on start.
- loop  in  1  1 = repeat forever, 0 = one-shot; sampled on start.
- start  in  1  pulse: begin scrolling from position 0.
- stop  in  1  pulse: abort to IDLE.
- pause  in  1  freeze scrolling (only with MARQUEE_PAUSE_EN).
- digits  out  N_DIGITS*SYM_W  digit k at bits [k*SYM_W +: SYM_W]; k=0 is leftmost.
- busy  out  1  high in SCROLL.
- done  out  1  one-cycle pulse at one-shot completion.
- pos  out  clog2(MAX_LEN+N_DIGITS)+1  current window position.

Behaviour:
- Reset:
  - State IDLE; pos=0, tick counter=0, busy=0, done=0.
  - All digits = BLANK.
  - Buffer contents are not cleared.
- States: IDLE, SCROLL, DONE.
- IDLE -> SCROLL on start with effective length L>0.
  - L = min(msg_len, MAX_LEN).
  - L and loop are latched; pos=0, tick counter=0.
- start with L=0: go to DONE for one cycle. done=1 next cycle, with no scrolling.
- SCROLL:
  - The tick counter counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps and pos advances.
  - The last position is P_END = L+N_DIGITS.
  - At pos=P_END with a tick: if loop=1, pos wraps to 0 and the state stays SCROLL. Otherwise go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. pos is held at P_END, so all digits are blank.
- Window mapping, registered with 1-cycle latency after pos changes:
  - idx = pos - N_DIGITS + k.
  - digit k = buf[idx] if 0 <= idx < L, else BLANK.
  - pos=0 gives all blank. pos=1 shows symbol 0 on the rightmost digit (k=N_DIGITS-1).
- In IDLE, all digits = BLANK.
- start while in SCROLL: restart at pos=0 with newly sampled msg_len and loop. No done pulse.
- stop has priority over start in the same cycle. stop goes to IDLE immediately, no done pulse, and digits blank next cycle.
- Writes are accepted in any state. A write to a visible index shows up on digits within 2 cycles.
- Write and window read of the same index in the same cycle: the read returns the old value.
- wr_addr >= MAX_LEN: the write is ignored.
- rst mid-scroll: returns to the reset state in the next cycle. rst has priority over stop and start.
- All arithmetic is unsigned, with widths wide enough that pos never overflows at P_END.

Optional Feature:
- Macro: MARQUEE_PAUSE_EN.
- Defined: while pause=1 in SCROLL, the tick counter and pos hold and digits stay frozen. start, stop and rst still act. Releasing pause resumes from the held tick count.
- Undefined: the pause port exists but is ignored, and the logic is removed.

Test Plan:
- Setup for all scenarios: N_DIGITS=8, MAX_LEN=32, TICK_DIV=4.
- Load buf[0..2]={1,2,3}, msg_len=3, loop=0, start:
  - pos steps 0..11, one step every 4 cycles.
  - At pos=1, digit7=1. At pos=3, digits5..7=1,2,3.
  - At pos=10, digit0=3 and all others blank.
  - done pulses once after the pos=11 tick, then busy=0.
- Same message with loop=1: after pos=11, pos returns to 0; no done pulse over 3 full passes.
- start with msg_len=0 -> done=1 exactly one cycle later; busy stays 0; digits all BLANK.
- Mid-scroll at pos=5:
  - stop -> IDLE next cycle, digits BLANK, no done.
  - Repeat with start instead -> pos=0 and counting restarts.
- msg_len=40 -> clamped to L=32; P_END=40; done after 41 steps.
- With MARQUEE_PAUSE_EN, pause=1 for 20 cycles at pos=4 -> pos stays 4, digits unchanged; after release, the next step occurs after the remaining tick count.
